// File: rtl/d_input_conditioner.sv
// d_input_conditioner
//
// Turns a raw asynchronous level (pin or switch) into a clean, synchronized,
// debounced level for the d input of a downstream flip-flop. It also gives
// one-cycle rise/fall strobes and a saturating count of aborted transitions,
// which is useful during bring-up.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   raw_in        raw level with no timing relation to clk
//   d_out         debounced level
//   rise_pulse    one-cycle strobe, asserted on the same edge that d_out goes 0->1
//   fall_pulse    one-cycle strobe, asserted on the same edge that d_out goes 1->0
//   glitch_count  number of aborted transitions, saturates at all-ones
//
// States
//   STABLE_LO | d_out=0, waiting for the synchronized level to go high
//   CHK_HI    | level is high, counting consecutive high cycles before committing
//   STABLE_HI | d_out=1, waiting for the synchronized level to go low
//   CHK_LO    | level is low, counting consecutive low cycles before committing

module d_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_in,
    output logic                d_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("d_input_conditioner: SYNC_STAGES must be in 2..4");
        end
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
            $error("d_input_conditioner: DEBOUNCE_CYCLES must be in 2..255");
        end
        if (GLITCH_W < 1) begin : g_bad_glitch_w
            $error("d_input_conditioner: GLITCH_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   d_out_q, d_out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;
    logic [GLITCH_W-1:0]    glitch_inc;

    // raw_in goes through the synchronizer chain only; all other logic uses its last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    // The count holds at all-ones instead of wrapping.
    assign glitch_inc = (glitch_q == {GLITCH_W{1'b1}}) ? glitch_q : glitch_q + GLITCH_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_out_d  = d_out_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_q;

        unique case (state_q)
            STABLE_LO: begin
                if (sync_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!sync_q) begin
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    d_out_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (sync_q) begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    glitch_d = glitch_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    d_out_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                d_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            d_out_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_out_q  <= d_out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign d_out        = d_out_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_d_input_conditioner.sv
module tb_d_input_conditioner;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int GW = 8;
    localparam int GMAX = (1 << GW) - 1;
    localparam int NTAB = 27;

    typedef struct packed {
        logic          d;
        logic          rise;
        logic          fall;
        logic [GW-1:0] glitch;
    } exp_t;

    typedef struct {
        logic raw;
        exp_t exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          raw_in;
    logic          d_out;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [GW-1:0] glitch_count;

    d_input_conditioner #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .GLITCH_W       (GW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_in      (raw_in),
        .d_out       (d_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .glitch_count(glitch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_pass;
    int   n_checks;
    exp_t sb_q[$];
    vec_t tab[NTAB];

    // Reference model: counts consecutive synchronized samples that disagree
    // with the debounced level; a run that ends early is a glitch.
    logic m_sync[SS];
    logic m_d;
    int   m_run;
    int   m_glitch;

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
        m_d      = 1'b0;
        m_run    = 0;
        m_glitch = 0;
    endtask

    task automatic model_edge(input logic r, output exp_t e);
        logic old_sync;
        old_sync = m_sync[SS-1];
        for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = r;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (old_sync != m_d) begin
            m_run++;
            if (m_run == DC) begin
                m_d = old_sync;
                if (old_sync) e.rise = 1'b1;
                else          e.fall = 1'b1;
                m_run = 0;
            end
        end else begin
            if (m_run > 0 && m_glitch < GMAX) m_glitch++;
            m_run = 0;
        end
        e.d      = m_d;
        e.glitch = m_glitch[GW-1:0];
    endtask

    task automatic check_vec(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got d=%0b rise=%0b fall=%0b glitch=%0d, want d=%0b rise=%0b fall=%0b glitch=%0d",
                      name, got.d, got.rise, got.fall, got.glitch,
                      want.d, want.rise, want.fall, want.glitch);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0b, want %0b", name, got, want);
    endtask

    // One clock: drive raw, push expectation at the edge, compare at the next negedge.
    task automatic step(input string name, input logic r, input bit use_tab, input exp_t tab_exp);
        exp_t e, got, want;
        raw_in = r;
        @(posedge clk);
        model_edge(r, e);
        sb_q.push_back(use_tab ? tab_exp : e);
        @(negedge clk);
        want = sb_q.pop_front();
        got  = {d_out, rise_pulse, fall_pulse, glitch_count};
        check_vec(name, got, want);
    endtask

    task automatic mstep(input string name, input logic r);
        step(name, r, 1'b0, '0);
    endtask

    initial begin
        int   edges;
        int   cyc;
        int   len;
        logic lvl;

        n_pass   = 0;
        n_checks = 0;
        rst      = 1'b1;
        raw_in   = 1'b1;
        model_reset();

        // Clean rise (rows 0-9), clean fall (rows 10-17), single glitch (rows 18-26).
        for (int i = 0; i < NTAB; i++) begin
            tab[i].exp = '0;
            if (i < 10) begin
                tab[i].raw      = 1'b1;
                tab[i].exp.d    = (i >= 5);
                tab[i].exp.rise = (i == 5);
            end else if (i < 18) begin
                tab[i].raw      = 1'b0;
                tab[i].exp.d    = (i < 15);
                tab[i].exp.fall = (i == 15);
            end else begin
                tab[i].raw        = (i < 21);
                tab[i].exp.glitch = (i >= 23) ? GW'(1) : GW'(0);
            end
        end

        // Reset held with raw_in high: outputs stay quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("reset_hold", {d_out, rise_pulse, fall_pulse, glitch_count}, '0);
        end
        raw_in = 1'b0;
        rst    = 1'b0;
        model_reset();

        for (int i = 0; i < NTAB; i++) step($sformatf("table_row%0d", i), tab[i].raw, 1'b1, tab[i].exp);

        // Repeated 3-cycle glitches drive the counter into saturation.
        for (int g = 0; g < 300; g++) begin
            repeat (3) mstep("glitch_hi", 1'b1);
            repeat (5) mstep("glitch_lo", 1'b0);
        end
        n_checks++;
        if (glitch_count === GW'(GMAX)) n_pass++;
        else $display("FAIL glitch_saturate: got %0d, want %0d", glitch_count, GMAX);

        // Reset in the middle of CHK_HI (cnt=2 after the fourth edge).
        repeat (4) mstep("midchk_rise", 1'b1);
        rst = 1'b1;
        #1;
        check_vec("midchk_async_rst", {d_out, rise_pulse, fall_pulse, glitch_count}, '0);
        repeat (2) @(negedge clk);
        check_vec("midchk_rst_held", {d_out, rise_pulse, fall_pulse, glitch_count}, '0);
        rst = 1'b0;
        model_reset();
        edges = 0;
        while (d_out !== 1'b1 && edges < 20) begin
            mstep("post_rst_rise", 1'b1);
            edges++;
        end
        n_checks++;
        if (edges == SS + DC) n_pass++;
        else $display("FAIL post_rst_latency: got %0d edges, want %0d", edges, SS + DC);

        // Reset while STABLE_HI: d_out drops at once, no fall strobe.
        repeat (3) mstep("hold_hi", 1'b1);
        rst = 1'b1;
        #1;
        check_bit("hi_rst_d_out", d_out, 1'b0);
        check_bit("hi_rst_fall", fall_pulse, 1'b0);
        @(negedge clk);
        check_bit("hi_rst_fall_later", fall_pulse, 1'b0);
        raw_in = 1'b0;
        rst    = 1'b0;
        model_reset();

        // Random toggling against the model, every cycle.
        cyc = 0;
        lvl = 1'b0;
        while (cyc < 2000) begin
            len = $urandom_range(1, 12);
            lvl = ~lvl;
            for (int k = 0; k < len; k++) begin
                mstep("random", lvl);
                n_checks++;
                if (!(rise_pulse && fall_pulse)) n_pass++;
                else $display("FAIL pulse_exclusive: got rise=1 fall=1, want not both");
            end
            cyc += len;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
